// File: rtl/motion_sequencer_pkg.sv
// Shared opcodes, FSM encoding and opcode helpers for the motion sequencer.
package motion_pkg;

    localparam logic [2:0] OP_STRAIGHT = 3'b000;
    localparam logic [2:0] OP_RIGHT    = 3'b001;
    localparam logic [2:0] OP_LEFT     = 3'b010;
    localparam logic [2:0] OP_STOP     = 3'b011;
    localparam logic [2:0] OP_TURN180  = 3'b100;
    localparam logic [2:0] OP_REVERSE  = 3'b101;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_BRAKE = 2'd2
    } fsm_e;

    // Forward motion is the only motion an obstacle can block.
    function automatic logic is_forward(input logic [2:0] op);
        return (op == OP_STRAIGHT) || (op == OP_RIGHT) || (op == OP_LEFT);
    endfunction

    function automatic logic is_valid_op(input logic [2:0] op);
        return (op <= OP_REVERSE);
    endfunction

endpackage

// File: rtl/motion_sequencer_if.sv
// Command channel between the CPU register block (master) and the sequencer (slave).
interface motion_sequencer_if #(
    parameter int DUR_W = 16
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [2:0]       cmd_op;
    logic [DUR_W-1:0] cmd_dur;

    modport master (output cmd_valid, output cmd_op, output cmd_dur, input  cmd_ready);
    modport slave  (input  cmd_valid, input  cmd_op, input  cmd_dur, output cmd_ready);
endinterface

// File: rtl/motion_sequencer_tick_gen.sv
// Duration prescaler: counts 0..TICK_DIV-1 and flags the last count as a one-cycle tick.
module tick_gen #(
    parameter int TICK_DIV = 100000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    output logic tick_o
);
    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    assign tick_o = (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (clr_i || tick_o) cnt_d = '0;
    end

    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end
endmodule

// File: rtl/motion_sequencer.sv
// Timed motion-command sequencer with obstacle/abort overrides and brake interval.
// Optional line steering of straight runs is enabled by defining MOTION_LINE_TRACK_EN.
module motion_sequencer
    import motion_pkg::*;
#(
    parameter int TICK_DIV    = 100000,
    parameter int DUR_W       = 16,
    parameter int BRAKE_TICKS = 50
) (
    input  logic                clk,
    input  logic                rst,
    motion_sequencer_if.slave   cmd,
    input  logic                obstacle,
    input  logic                abort,
    input  logic [2:0]          line,
    output logic [2:0]          state,
    output logic                busy,
    output logic                done,
    output logic                aborted
);
    localparam logic [DUR_W-1:0] BRAKE_LOAD = DUR_W'(BRAKE_TICKS);

    fsm_e             fsm_q, fsm_d;
    logic [2:0]       op_q, op_d;
    logic [DUR_W-1:0] cnt_q, cnt_d;
    logic             indef_q, indef_d;
    logic             mark_q, mark_d;
    logic [2:0]       state_q, state_d;
    logic             done_q, done_d;
    logic             aborted_q, aborted_d;
    logic             presc_clr;
    logic             tick;
    logic             accept;
    logic             launch;
    logic [2:0]       run_code;

    tick_gen #(.TICK_DIV(TICK_DIV)) u_tick_gen (
        .clk    (clk),
        .rst    (rst),
        .clr_i  (presc_clr),
        .tick_o (tick)
    );

`ifdef MOTION_LINE_TRACK_EN
    logic [2:0] line_s1_q, line_s2_q;

    function automatic logic [2:0] steer(input logic [2:0] l);
        case (l)
            3'b100, 3'b110: return OP_LEFT;
            3'b001, 3'b011: return OP_RIGHT;
            3'b000:         return OP_STOP;
            default:        return OP_STRAIGHT;
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            line_s1_q <= '0;
            line_s2_q <= '0;
        end else begin
            line_s1_q <= line;
            line_s2_q <= line_s1_q;
        end
    end

    assign run_code = (op_d == OP_STRAIGHT) ? steer(line_s2_q) : op_d;
`else
    logic line_unused;
    assign line_unused = ^line;
    assign run_code    = op_d;
`endif

    assign cmd.cmd_ready = !rst && ((fsm_q == S_IDLE) || ((fsm_q == S_RUN) && indef_q));
    assign accept        = cmd.cmd_valid && cmd.cmd_ready;

    always_comb begin
        fsm_d     = fsm_q;
        op_d      = op_q;
        cnt_d     = cnt_q;
        indef_d   = indef_q;
        mark_d    = mark_q;
        done_d    = 1'b0;
        aborted_d = 1'b0;
        presc_clr = 1'b0;
        launch    = 1'b0;
        state_d   = OP_STOP;

        if (tick && (cnt_q != '0)) cnt_d = cnt_q - 1'b1;

        unique case (fsm_q)
            S_IDLE: begin
                if (accept) launch = 1'b1;
            end
            S_RUN: begin
                // A newly accepted command preempts an indefinite one without braking.
                if (accept) begin
                    launch = 1'b1;
                end else if (abort || (obstacle && is_forward(op_q))) begin
                    fsm_d     = S_BRAKE;
                    mark_d    = 1'b1;
                    cnt_d     = BRAKE_LOAD;
                    presc_clr = 1'b1;
                end else if (!indef_q && tick && (cnt_q == DUR_W'(1))) begin
                    fsm_d     = S_BRAKE;
                    mark_d    = 1'b0;
                    cnt_d     = BRAKE_LOAD;
                    presc_clr = 1'b1;
                end
            end
            S_BRAKE: begin
                if ((cnt_q == '0) || (tick && (cnt_q == DUR_W'(1)))) begin
                    fsm_d     = S_IDLE;
                    done_d    = !mark_q;
                    aborted_d = mark_q;
                    mark_d    = 1'b0;
                end
            end
            default: fsm_d = S_IDLE;
        endcase

        if (launch) begin
            // Invalid opcodes are consumed and rejected; any running command continues.
            if (!is_valid_op(cmd.cmd_op)) begin
                aborted_d = 1'b1;
            end else begin
                op_d      = cmd.cmd_op;
                indef_d   = (cmd.cmd_dur == '0);
                presc_clr = 1'b1;
                if (obstacle && is_forward(cmd.cmd_op)) begin
                    fsm_d  = S_BRAKE;
                    mark_d = 1'b1;
                    cnt_d  = BRAKE_LOAD;
                end else begin
                    fsm_d  = S_RUN;
                    mark_d = 1'b0;
                    cnt_d  = DUR_W'(cmd.cmd_dur);
                end
            end
        end

        if (fsm_d == S_RUN) state_d = run_code;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fsm_q     <= S_IDLE;
            op_q      <= OP_STOP;
            cnt_q     <= '0;
            indef_q   <= 1'b0;
            mark_q    <= 1'b0;
            state_q   <= OP_STOP;
            done_q    <= 1'b0;
            aborted_q <= 1'b0;
        end else begin
            fsm_q     <= fsm_d;
            op_q      <= op_d;
            cnt_q     <= cnt_d;
            indef_q   <= indef_d;
            mark_q    <= mark_d;
            state_q   <= state_d;
            done_q    <= done_d;
            aborted_q <= aborted_d;
        end
    end

    assign state   = state_q;
    assign busy    = (fsm_q != S_IDLE);
    assign done    = done_q;
    assign aborted = aborted_q;
endmodule
